// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: funct3 encodings, funct7 tag
// and the controller state type.
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix,
    StDone
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared multiply/divide datapath: radix-2 shift-add for multiply,
// restoring subtract for divide. Accumulator is {hi, lo}.
module muldiv_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic              is_div,
  input  logic [2*XLEN-1:0] acc_in,
  input  logic [XLEN-1:0]   operand,
  output logic [2*XLEN-1:0] acc_out
);

  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;

  always_comb begin
    hi      = acc_in[2*XLEN-1:XLEN];
    lo      = acc_in[XLEN-1:0];
    // Multiply: lo holds the remaining multiplier bits, product shifts in from the top.
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, operand} : {(XLEN+1){1'b0}});
    // Divide: hi is the partial remainder, lo shifts dividend bits out and quotient bits in.
    shifted = {hi, lo[XLEN-1]};
    diff    = shifted - {1'b0, operand};
    if (is_div) begin
      if (diff[XLEN]) begin
        acc_out = {shifted[XLEN-1:0], lo[XLEN-2:0], 1'b0};
      end else begin
        acc_out = {diff[XLEN-1:0], lo[XLEN-2:0], 1'b1};
      end
    end else begin
      acc_out = {sum, lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M execute-stage unit: stalls the pipeline for XLEN iterations plus a sign-fix
// cycle, then presents the result for one cycle. Divide-by-zero and signed overflow bypass.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_operand1,
  input  logic [XLEN-1:0] in_operand2,
  input  logic            in_kill,
  output logic            out_stall,
  output logic            out_busy,
  output logic            out_done,
  output logic [XLEN-1:0] out_result
);

  localparam int unsigned CntW = $clog2(XLEN);

  muldiv_state_t     state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   res_q, res_d;

  logic [2*XLEN-1:0] step_acc;
  logic              op1_signed, op2_signed, a_neg, b_neg, in_is_div;
  logic              div_zero, div_ovf;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [2*XLEN-1:0] prod_fixed;
  logic [XLEN-1:0]   div_sel, div_fixed, fix_value;

  muldiv_step #(
    .XLEN(XLEN)
  ) u_step (
    .is_div  (f3_q[2]),
    .acc_in  (acc_q),
    .operand (opb_q),
    .acc_out (step_acc)
  );

  always_comb begin
    op1_signed = (in_funct3 == F3_MULH) || (in_funct3 == F3_MULHSU) ||
                 (in_funct3 == F3_DIV)  || (in_funct3 == F3_REM);
    op2_signed = (in_funct3 == F3_MULH) || (in_funct3 == F3_DIV) || (in_funct3 == F3_REM);
    a_neg      = op1_signed & in_operand1[XLEN-1];
    b_neg      = op2_signed & in_operand2[XLEN-1];
    mag_a      = a_neg ? -in_operand1 : in_operand1;
    mag_b      = b_neg ? -in_operand2 : in_operand2;
    in_is_div  = in_funct3[2];
    div_zero   = in_is_div && (in_operand2 == '0);
    div_ovf    = in_is_div && !in_funct3[0] &&
                 (in_operand1 == {1'b1, {(XLEN-1){1'b0}}}) && (in_operand2 == '1);

    prod_fixed = neg_q ? -acc_q : acc_q;
    div_sel    = f3_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
    div_fixed  = neg_q ? -div_sel : div_sel;
    if (f3_q[2]) begin
      fix_value = div_fixed;
    end else if (f3_q == F3_MUL) begin
      fix_value = prod_fixed[XLEN-1:0];
    end else begin
      fix_value = prod_fixed[2*XLEN-1:XLEN];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    f3_d    = f3_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    neg_d   = neg_q;
    res_d   = res_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid && !in_kill) begin
          f3_d  = in_funct3;
          // Remainder takes the dividend's sign; everything else the XOR of operand signs.
          neg_d = (in_is_div && in_funct3[1]) ? a_neg : (a_neg ^ b_neg);
          acc_d = {{XLEN{1'b0}}, mag_a};
          opb_d = mag_b;
          cnt_d = '0;
          if (div_zero) begin
            res_d   = in_funct3[1] ? in_operand1 : '1;
            state_d = StDone;
          end else if (div_ovf) begin
            res_d   = in_funct3[1] ? '0 : in_operand1;
            state_d = StDone;
          end else begin
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        if (in_kill) begin
          state_d = StIdle;
        end else begin
          acc_d = step_acc;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntW'(XLEN - 1)) state_d = StFix;
        end
      end
      StFix: begin
        if (in_kill) begin
          state_d = StIdle;
        end else begin
          res_d   = fix_value;
          state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      f3_q    <= '0;
      acc_q   <= '0;
      opb_q   <= '0;
      neg_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      f3_q    <= f3_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      neg_q   <= neg_d;
      res_q   <= res_d;
    end
  end

  // Stall is combinational in IDLE so the issuing instruction is held in EX on its first cycle.
  assign out_stall  = !reset && (((state_q == StIdle) && in_valid) ||
                                 (state_q == StCalc) || (state_q == StFix));
  assign out_busy   = (state_q != StIdle);
  assign out_done   = (state_q == StDone) && !in_kill;
  assign out_result = res_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: arithmetic/latency model checked every cycle, plus directed
// vectors with hand-computed results, kill, async reset and back-to-back issue.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [2:0]  in_funct3;
  logic [31:0] in_operand1;
  logic [31:0] in_operand2;
  logic        in_kill;
  logic        out_stall;
  logic        out_busy;
  logic        out_done;
  logic [31:0] out_result;

  muldiv_sequencer #(
    .XLEN(32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_funct3   (in_funct3),
    .in_operand1 (in_operand1),
    .in_operand2 (in_operand2),
    .in_kill     (in_kill),
    .out_stall   (out_stall),
    .out_busy    (out_busy),
    .out_done    (out_done),
    .out_result  (out_result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model: an op issued at cycle t0 completes lat cycles later with exp_res.
  bit          act = 1'b0;
  int          t0, lat, k;
  logic [31:0] exp_res;
  logic [31:0] last_res = 32'h0;
  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic logic [31:0] model_res(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [63:0] sa, sb, ubs;
    logic [63:0]        p;
    logic               ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ubs = {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = 64'h0;
    case (f)
      3'b000: begin p = sa * sb; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * ubs; return p[63:32]; end
      3'b011: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        p = sa / sb;
        return p[31:0];
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = sa % sb;
        return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] f, input logic [31:0] a,
                                   input logic [31:0] b);
    bit fast;
    fast = f[2] && ((b == 0) ||
                    (!f[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)));
    return fast ? 1 : 34;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (out_done === 1'b1) done_cnt++;
      if (act) begin
        k = cyc - t0;
        check("stall", 32'(out_stall), 32'(k < lat));
        check("busy", 32'(out_busy), 32'((k >= 1) && (k <= lat)));
        check("done", 32'(out_done), 32'(k == lat));
        if (k == lat) begin
          check("result", out_result, exp_res);
          last_res = exp_res;
          act = 1'b0;
        end else begin
          check("held_result", out_result, last_res);
        end
      end else begin
        check("idle_stall", 32'(out_stall), 32'(in_valid));
        check("idle_busy", 32'(out_busy), 32'h0);
        check("idle_done", 32'(out_done), 32'h0);
        check("idle_result", out_result, last_res);
      end
    end
  end

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1;
    in_funct3   = f;
    in_operand1 = a;
    in_operand2 = b;
    in_valid    = 1'b1;
    t0          = cyc;
    lat         = model_lat(f, a, b);
    exp_res     = model_res(f, a, b);
    act         = 1'b1;
  endtask

  task automatic wait_done(output int at);
    at = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_done === 1'b1) begin
        at = cyc;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL done_timeout: got no pulse want pulse (cycle %0d)", cyc);
  endtask

  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] want, input int want_lat);
    int at;
    issue(f, a, b);
    wait_done(at);
    check({name, "_value"}, out_result, want);
    check({name, "_latency"}, 32'(at - t0), 32'(want_lat));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    int n, at, tb0;
    reset       = 1'b1;
    in_valid    = 1'b1;
    in_kill     = 1'b0;
    in_funct3   = 3'b000;
    in_operand1 = 32'h0;
    in_operand2 = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", 32'(out_stall), 32'h0);
    check("rst_busy", 32'(out_busy), 32'h0);
    check("rst_done", 32'(out_done), 32'h0);
    check("rst_result", out_result, 32'h0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;

    run_op("mul",    3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
    run_op("mulhu",  3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    run_op("mulh",   3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34);
    run_op("mulhsu", 3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
    run_op("div",    3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34);
    run_op("rem",    3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34);
    run_op("divu",   3'b101, 32'd100,        32'd7,         32'd14,        34);
    run_op("remu",   3'b111, 32'd100,        32'd7,         32'd2,         34);
    run_op("divu_z", 3'b101, 32'd5,          32'd0,         32'hFFFF_FFFF, 1);
    run_op("rem_z",  3'b110, 32'd5,          32'd0,         32'd5,         1);
    run_op("div_ov", 3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);

    // Kill in the middle of a divide: back to idle, no pulse, result untouched.
    n = done_cnt;
    issue(3'b100, 32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    #1;
    in_kill  = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    in_kill = 1'b0;
    act     = 1'b0;
    check("kill_busy", 32'(out_busy), 32'h0);
    check("kill_stall", 32'(out_stall), 32'h0);
    repeat (40) @(posedge clk);
    check("kill_no_done", 32'(done_cnt - n), 32'h0);

    // Async reset mid-divide: outputs clear without waiting for a clock edge.
    issue(3'b100, 32'd1000, 32'd3);
    repeat (20) @(posedge clk);
    #1;
    reset    = 1'b1;
    act      = 1'b0;
    last_res = 32'h0;
    #1;
    check("arst_stall", 32'(out_stall), 32'h0);
    check("arst_busy", 32'(out_busy), 32'h0);
    check("arst_done", 32'(out_done), 32'h0);
    check("arst_result", out_result, 32'h0);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;

    // Back-to-back with in_valid held across the DONE cycle.
    n = done_cnt;
    issue(3'b000, 32'd3, 32'd4);
    tb0 = t0;
    wait_done(at);
    check("b2b_mul_value", out_result, 32'd12);
    check("b2b_mul_at", 32'(at - tb0), 32'd34);
    issue(3'b101, 32'd12, 32'd5);
    wait_done(at);
    check("b2b_divu_value", out_result, 32'd2);
    check("b2b_divu_at", 32'(at - tb0), 32'd69);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (40) @(posedge clk);
    check("b2b_pulses", 32'(done_cnt - n), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Iterative multi-cycle controller and datapath for RV32M (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU), sitting beside the ALU in the execute stage. It takes already-forwarded operands, freezes the front of the pipeline with out_stall while iterating, then presents the result for exactly one cycle. The execute stage muxes this result onto the ALU output when the instruction is M-extension.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  ID/EX holds an M-extension op (opcode 0110011, funct7 0000001)
in_funct3  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
in_operand1  input  XLEN  rs1 value after forwarding mux
in_operand2  input  XLEN  rs2 value after forwarding mux
in_kill  input  1  abort the in-flight op (pipeline squash)
out_stall  output  1  hold PC, IF/ID, ID/EX and insert bubble into EX/MEM
out_busy  output  1  state != IDLE
out_done  output  1  one-cycle pulse; out_result valid
out_result  output  XLEN  product/quotient/remainder

Behaviour:
- Reset (async): state IDLE, counter 0, internal registers 0, out_done 0, out_result 0, out_busy 0. out_stall is 0 while reset is high.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - in_valid && !in_kill: latch funct3, operand magnitudes (signed ops take abs of signed operands), result-sign flags.
  - Fast paths go directly to DONE:
    - divisor==0: quotient 0xFFFFFFFF, remainder = dividend.
    - Signed DIV/REM with 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
  - Otherwise go to CALC with counter 0.
- CALC:
  - Multiply: radix-2 shift-add into a 2*XLEN accumulator, one bit per cycle.
  - Divide: restoring, one quotient bit per cycle.
  - Runs exactly XLEN cycles, then goes to FIX.
- FIX: apply two's-complement negation as required, select the high/low word or quotient/remainder, register out_result, go to DONE.
  - REM sign follows the dividend.
  - MULHSU: rs1 signed, rs2 unsigned.
- DONE: out_done=1 and out_result stable for this cycle only; return to IDLE. out_result holds its value afterwards until the next FIX or fast path.
- out_stall = (IDLE && in_valid) || CALC || FIX. It is combinational in IDLE so the issuing instruction does not leave EX, and it is low in DONE so the pipeline advances with the result.
- Latency, normal path: issue cycle T0, CALC T1..T32, FIX T33, DONE T34. Stall is high T0..T33.
- Latency, fast path: T0 issue, DONE T1, stall high only at T0.
- Back-to-back: in DONE the instruction leaves ID/EX. The next cycle is IDLE and may immediately accept a following M-op. No op is ever started twice.
- in_kill:
  - In any non-IDLE state: go to IDLE next edge, no out_done pulse, out_result unchanged.
  - In IDLE: suppresses start.
  - Has priority over start and over a DONE transition.
- Async reset mid-operation: abort immediately, all outputs to reset values.
- in_valid and operands are sampled only in IDLE. Changes during CALC/FIX/DONE are ignored.
- Arithmetic: XLEN-bit unsigned internal magnitudes, 2*XLEN product accumulator, XLEN+1-bit partial remainder. No flags or exceptions are raised.

Decomposition:
- Shared package muldiv_pkg holds:
  - funct3 constants: F3_MUL, F3_MULH, F3_MULHSU, F3_MULHU, F3_DIV, F3_DIVU, F3_REM, F3_REMU.
  - M-extension funct7 constant 7'b0000001.
  - State enum type muldiv_state_t.
- One natural sub-module, muldiv_step: combinational single-iteration step (shift-add or restore-subtract), instantiated once. The FSM, counter and sign fix stay in muldiv_sequencer.

Test Plan:
- MUL 7 × 0xFFFFFFFD: result 0xFFFFFFEB. out_stall high T0..T33, out_done pulse at T34 only.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF: result 0xFFFFFFFE. MULH 0x80000000 × 0x80000000: result 0x40000000. MULHSU 0xFFFFFFFF × 0xFFFFFFFF: result 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2: result 0xFFFFFFFD. REM same operands: result 0xFFFFFFFF. DIVU 100 / 7: result 14. REMU same operands: result 2.
- Fast paths:
  - DIVU 5 / 0: result 0xFFFFFFFF with out_done at T1.
  - REM 5 / 0: result 5.
  - DIV 0x80000000 / 0xFFFFFFFF: result 0x80000000 at T1.
  - In each case stall is high only at T0.
- Start a DIV, pulse in_kill at T10: IDLE at T11, no out_done, out_busy 0. Repeat with async reset at T20: all outputs 0 immediately.
- Back-to-back MUL 3×4 then DIVU 12/5 with in_valid held: out_done pulses at T34 (12) and T69 (2). Exactly two pulses, no duplicate start.
